lcd_bus_reader: RTL

Read-side companion to the team's HD44780 (CFAH1602B) write state machine. It runs HD44780 read cycles (RW=1) from the 50 MHz domain: a busy-flag/address-counter read (RS=0) or a DDRAM/CGRAM data read (RS=1). An optional poll mode repeats busy-flag reads until BF=0 or a poll limit is reached. The top level muxes LCD_RS/LCD_RW/LCD_E between this block and the writer. The writer tri-states DATA_BUS whenever RW=1, so this block only samples the bus.

---
 rtl/lcd_bus_reader.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/lcd_bus_reader.sv
// HD44780 read-cycle sequencer: busy-flag/address or data reads, with optional busy polling.
// Define LCD_READ_SYNC_EN to pass DATA_BUS through a 2-flop synchronizer before capture.
module lcd_bus_reader #(
  parameter int unsigned SETUP_CYC  = 3,
  parameter int unsigned E_HIGH_CYC = 16,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned GAP_CYC    = 8,
  parameter int unsigned MAX_POLLS  = 4000
) (
  input  logic       iCLK_50MHZ,
  input  logic       iRST_N,
  input  logic       iREQ,
  input  logic       iRS,
  input  logic       iPOLL,
  input  logic [7:0] DATA_BUS,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic [7:0] oDATA,
  output logic       oVALID,
  output logic       oTIMEOUT,
  output logic       oBUSY
);

`ifdef LCD_READ_SYNC_EN
  localparam int unsigned SYNC_EXTRA = 2;
  localparam int          CNT_W      = 9;
`else
  localparam int unsigned SYNC_EXTRA = 0;
  localparam int          CNT_W      = 8;
`endif

  localparam int unsigned E_LEN = E_HIGH_CYC + SYNC_EXTRA;

  // Down-counter reload values; a phase ends on the edge where the counter is zero.
  // The first setup after acceptance loads one more, covering the acceptance cycle.
  localparam logic [CNT_W-1:0] SETUP_FIRST = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] E_LOAD      = CNT_W'(E_LEN - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYC - 1);
  localparam logic [15:0]      POLL_MAX    = 16'(MAX_POLLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_E_HIGH,
    S_HOLD,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      poll_cnt_q;
  logic             poll_q;
  logic             rs_q;
  logic             rw_q;
  logic             e_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             timeout_q;
  logic             busy_q;
  logic [7:0]       cap_src;

`ifdef LCD_READ_SYNC_EN
  logic [7:0] sync1_q;
  logic [7:0] sync2_q;

  // NOTE: synchronizer flops are ordinary registers, so they take the reset like all other state.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
    end else begin
      sync1_q <= DATA_BUS;
      sync2_q <= sync1_q;
    end
  end

  assign cap_src = sync2_q;
`else
  assign cap_src = DATA_BUS;
`endif

  // NOTE: non-blocking assignments throughout, so every register sees the pre-edge values.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      poll_cnt_q <= 16'd0;
      poll_q     <= 1'b0;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      e_q        <= 1'b0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (iREQ) begin
            state_q    <= S_SETUP;
            cnt_q      <= SETUP_FIRST;
            poll_cnt_q <= 16'd1;
            poll_q     <= iPOLL & ~iRS;
            rs_q       <= iRS;
            rw_q       <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_SETUP: begin
          if (cnt_q == '0) begin
            state_q <= S_E_HIGH;
            cnt_q   <= E_LOAD;
            e_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_E_HIGH: begin
          if (cnt_q == '0) begin
            state_q <= S_HOLD;
            cnt_q   <= HOLD_LOAD;
            e_q     <= 1'b0;
            data_q  <= cap_src;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            state_q <= S_GAP;
            cnt_q   <= GAP_LOAD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (poll_q && data_q[7] && (poll_cnt_q < POLL_MAX)) begin
            state_q    <= S_SETUP;
            cnt_q      <= SETUP_LOAD;
            poll_cnt_q <= poll_cnt_q + 16'd1;
          end else begin
            state_q   <= S_DONE;
            valid_q   <= 1'b1;
            timeout_q <= poll_q & data_q[7];
            rs_q      <= 1'b0;
            rw_q      <= 1'b0;
          end
        end
        S_DONE: begin
          state_q    <= S_IDLE;
          valid_q    <= 1'b0;
          timeout_q  <= 1'b0;
          busy_q     <= 1'b0;
          poll_q     <= 1'b0;
          poll_cnt_q <= 16'd0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign LCD_RS   = rs_q;
  assign LCD_RW   = rw_q;
  assign LCD_E    = e_q;
  assign oDATA    = data_q;
  assign oVALID   = valid_q;
  assign oTIMEOUT = timeout_q;
  assign oBUSY    = busy_q;

endmodule
